// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with return-address stack, trap capture and alignment check
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter int              INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4,
    parameter int              STATE_W      = 3,
    parameter int              FETCH_STATE  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [STATE_W-1:0]             state,
    input  logic                           stall,
    input  logic [1:0]                     pc_src,
    input  logic                           is_call,
    input  logic                           trap,
    input  logic [XLEN-1:0]                pc_branch,
    input  logic [XLEN-1:0]                pc_jump,
    input  logic [XLEN-1:0]                trap_vector,
    output logic [XLEN-1:0]                pc_out,
    output logic [XLEN-1:0]                pc_next,
    output logic [XLEN-1:0]                epc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           misalign,
    output logic [XLEN-1:0]                fault_addr
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(INST_BYTES);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [XLEN-1:0]  fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic             upd;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_we;
    logic             mis_hit;
    logic [XLEN-1:0]  seq;
    logic [XLEN-1:0]  ras_top;

    assign upd       = (state == STATE_W'(FETCH_STATE)) && !stall;
    assign seq       = pc_q + XLEN'(INST_BYTES);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_q[wptr_q - PTR_W'(1)];

    always_comb begin
        pc_next = seq;
        if (trap) begin
            pc_next = trap_vector;
        end else begin
            case (pc_src)
                2'd3:    pc_next = ras_empty ? pc_jump : ras_top;
                2'd2:    pc_next = pc_jump;
                2'd1:    pc_next = pc_branch;
                default: pc_next = seq;
            endcase
        end
    end

    // The trap vector is trusted; only ordinary control flow is alignment-checked.
    assign mis_hit = !trap && (pc_next[OFF_W-1:0] != '0);

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        mis_d   = 1'b0;
        ras_we  = 1'b0;
        if (upd) begin
            if (trap) begin
                pc_d  = trap_vector;
                epc_d = pc_q;
            end else if (mis_hit) begin
                mis_d   = 1'b1;
                fault_d = pc_next;
            end else begin
                pc_d = pc_next;
                if (pc_src == 2'd2 && is_call) begin
                    // When full, wptr already points at the oldest entry, so the write overwrites it.
                    ras_we = 1'b1;
                    wptr_d = wptr_q + PTR_W'(1);
                    if (ras_full) ovf_d = 1'b1;
                    else          cnt_d = cnt_q + CNT_W'(1);
                end else if (pc_src == 2'd3) begin
                    if (ras_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        wptr_d = wptr_q - PTR_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            fault_q <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_q[wptr_q] <= seq;
    end

    assign pc_out        = pc_q;
    assign epc           = epc_q;
    assign fault_addr    = fault_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign misalign      = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic        stall;
    logic [1:0]  pc_src;
    logic        is_call;
    logic        trap;
    logic [63:0] pc_branch;
    logic [63:0] pc_jump;
    logic [63:0] trap_vector;
    logic [63:0] pc_out;
    logic [63:0] pc_next;
    logic [63:0] epc;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        misalign;
    logic [63:0] fault_addr;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .state(state), .stall(stall), .pc_src(pc_src),
        .is_call(is_call), .trap(trap), .pc_branch(pc_branch), .pc_jump(pc_jump),
        .trap_vector(trap_vector), .pc_out(pc_out), .pc_next(pc_next), .epc(epc),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .misalign(misalign), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] st, input logic stl, input logic [1:0] src,
                         input logic call, input logic trp, input logic [63:0] br,
                         input logic [63:0] jmp, input logic [63:0] tv);
        state = st; stall = stl; pc_src = src; is_call = call; trap = trp;
        pc_branch = br; pc_jump = jmp; trap_vector = tv;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        cyc(); cyc();
        total++; if (pc_out !== 64'h0) begin bad++; $display("FAIL reset_pc got %h want 0", pc_out); end
        total++; if ({epc, fault_addr} !== 128'h0) begin bad++; $display("FAIL reset_epc_fault got %h %h want 0 0", epc, fault_addr); end
        total++; if ({ras_count, ras_overflow, ras_underflow, misalign} !== 6'h0) begin bad++;
            $display("FAIL reset_ras_pulses got %b want 000000", {ras_count, ras_overflow, ras_underflow, misalign}); end
        reset = 1'b0;
        // advance to 0x40 via a jump, then reset asynchronously mid-cycle
        drive(3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 64'h0, 64'h40, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h40) begin bad++; $display("FAIL pre_reset_pc got %h want 40", pc_out); end
        #2 reset = 1'b1;
        #1;
        total++; if (pc_out !== 64'h0) begin bad++; $display("FAIL async_reset_pc got %h want 0", pc_out); end
        #1 reset = 1'b0;
    endtask

    task automatic test_sequential();
        drive(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            total++; if (pc_out !== 64'(4 * i)) begin bad++; $display("FAIL seq_%0d got %h want %h", i, pc_out, 64'(4 * i)); end
        end
    endtask

    task automatic test_stall_hold();
        drive(3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0);
        #1;
        total++; if (pc_next !== 64'h100) begin bad++; $display("FAIL stall_pc_next got %h want 100", pc_next); end
        cyc();
        total++; if (pc_out !== 64'hC) begin bad++; $display("FAIL stall_hold got %h want c", pc_out); end
        drive(3'b010, 1'b0, 2'd1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0);
        cyc();
        total++; if (pc_out !== 64'hC) begin bad++; $display("FAIL nonfetch_hold got %h want c", pc_out); end
        drive(3'd0, 1'b0, 2'd1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h100) begin bad++; $display("FAIL branch got %h want 100", pc_out); end
    endtask

    task automatic test_call_return();
        drive(3'd0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h0, 64'h200, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h200 || ras_count !== 3'd1) begin bad++;
            $display("FAIL call got pc=%h cnt=%0d want pc=200 cnt=1", pc_out, ras_count); end
        drive(3'd0, 1'b0, 2'd3, 1'b0, 1'b0, 64'h0, 64'h999, 64'h0);
        #1;
        total++; if (pc_next !== 64'h104) begin bad++; $display("FAIL ret_pc_next got %h want 104", pc_next); end
        cyc();
        total++; if (pc_out !== 64'h104 || ras_count !== 3'd0) begin bad++;
            $display("FAIL ret got pc=%h cnt=%0d want pc=104 cnt=0", pc_out, ras_count); end
        drive(3'd0, 1'b0, 2'd3, 1'b0, 1'b0, 64'h0, 64'h300, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h300 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin bad++;
            $display("FAIL underflow got pc=%h unf=%b cnt=%0d want pc=300 unf=1 cnt=0", pc_out, ras_underflow, ras_count); end
        drive(3'd0, 1'b1, 2'd3, 1'b0, 1'b0, 64'h0, 64'h300, 64'h0);
        cyc();
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL underflow_clear got %b want 0", ras_underflow); end
    endtask

    task automatic test_ras_overflow();
        logic [63:0] exp_ret [4];
        exp_ret[0] = 64'h4004; exp_ret[1] = 64'h3004; exp_ret[2] = 64'h2004; exp_ret[3] = 64'h1004;
        // pushes 0x304, 0x1004, 0x2004, 0x3004, 0x4004; the fifth evicts 0x304
        for (int i = 1; i <= 5; i++) begin
            drive(3'd0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h0, 64'(i * 'h1000), 64'h0);
            cyc();
        end
        total++; if (pc_out !== 64'h5000 || ras_count !== 3'd4 || ras_overflow !== 1'b1) begin bad++;
            $display("FAIL overflow got pc=%h cnt=%0d ovf=%b want pc=5000 cnt=4 ovf=1", pc_out, ras_count, ras_overflow); end
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 1'b0, 2'd3, 1'b0, 1'b0, 64'h0, 64'hEEE0, 64'h0);
            cyc();
            total++; if (pc_out !== exp_ret[i] || ras_count !== 3'(3 - i) || ras_overflow !== 1'b0) begin bad++;
                $display("FAIL pop_%0d got pc=%h cnt=%0d ovf=%b want pc=%h cnt=%0d ovf=0",
                         i, pc_out, ras_count, ras_overflow, exp_ret[i], 3 - i); end
        end
    endtask

    task automatic test_trap();
        drive(3'd0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h0, 64'h208, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h208 || ras_count !== 3'd1) begin bad++;
            $display("FAIL pre_trap got pc=%h cnt=%0d want pc=208 cnt=1", pc_out, ras_count); end
        drive(3'd0, 1'b0, 2'd2, 1'b1, 1'b1, 64'h0, 64'h400, 64'h800);
        cyc();
        total++; if (pc_out !== 64'h800 || epc !== 64'h208 || ras_count !== 3'd1) begin bad++;
            $display("FAIL trap got pc=%h epc=%h cnt=%0d want pc=800 epc=208 cnt=1", pc_out, epc, ras_count); end
    endtask

    task automatic test_misalign();
        drive(3'd0, 1'b0, 2'd1, 1'b0, 1'b0, 64'h102, 64'h0, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h800 || misalign !== 1'b1 || fault_addr !== 64'h102) begin bad++;
            $display("FAIL misalign got pc=%h mis=%b fault=%h want pc=800 mis=1 fault=102", pc_out, misalign, fault_addr); end
        drive(3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 64'h102, 64'h0, 64'h0);
        cyc();
        total++; if (misalign !== 1'b0 || fault_addr !== 64'h102) begin bad++;
            $display("FAIL misalign_clear got mis=%b fault=%h want mis=0 fault=102", misalign, fault_addr); end
    endtask

    task automatic test_wrap();
        drive(3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        cyc();
        total++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_setup got %h want fffffffffffffffc", pc_out); end
        drive(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        cyc();
        total++; if (pc_out !== 64'h0) begin bad++; $display("FAIL wrap got %h want 0", pc_out); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_call_return();
        test_ras_overflow();
        test_trap();
        test_misalign();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle CPU, replacing the single-register PC with a block that resolves five next-PC sources: sequential, branch, jump/call, return, and trap. It keeps a small circular return-address stack (RAS), captures the exception PC on traps, and rejects misaligned targets. The block sits at the front of the fetch path. It updates only in the fetch state of the control FSM.

## Interface
Parameters:
- XLEN, 64, PC and address width
- INST_BYTES, 4, sequential increment; a power of two, at least 2
- RESET_VECTOR, 0, PC value after reset
- RAS_DEPTH, 4, return-address stack entries; a power of two, at least 2
- STATE_W, 3, width of the control-FSM state input
- FETCH_STATE, 0, state encoding in which the PC may update

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-high reset
- state  in  STATE_W  current control-FSM state
- stall  in  1  blocks the update while high
- pc_src  in  2  next-PC select: 0 sequential, 1 branch, 2 jump, 3 return
- is_call  in  1  qualifies pc_src=2 as a call, which pushes onto the RAS
- trap  in  1  trap request; overrides pc_src
- pc_branch  in  XLEN  branch target
- pc_jump  in  XLEN  jump target; also the return fallback when the RAS is empty
- trap_vector  in  XLEN  trap handler address
- pc_out  out  XLEN  registered current PC
- pc_next  out  XLEN  combinational candidate next PC
- epc  out  XLEN  PC captured at the last trap
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries
- ras_overflow  out  1  one-cycle pulse: a push overwrote the oldest entry
- ras_underflow  out  1  one-cycle pulse: a return hit an empty RAS
- misalign  out  1  one-cycle pulse: an update was rejected
- fault_addr  out  XLEN  the rejected target

## Operation
- upd = (state == FETCH_STATE) && !stall. All state changes happen only on a rising clk edge where upd is high; otherwise every register holds.
- seq = pc_out + INST_BYTES, computed modulo 2^XLEN (wraps at the top of the address space).
- pc_next is selected by priority:
  - trap: trap_vector
  - pc_src=3 with RAS non-empty: RAS top
  - pc_src=3 with RAS empty: pc_jump
  - pc_src=2: pc_jump
  - pc_src=1: pc_branch
  - pc_src=0: seq
- Trap: pc_out ← trap_vector, epc ← pc_out. The RAS is untouched, and is_call and pc_src are ignored.
- Call (pc_src=2 and is_call, no trap): push seq onto the RAS.
  - If ras_count < RAS_DEPTH, ras_count increments.
  - If full, the oldest entry is overwritten, ras_count stays at RAS_DEPTH, and ras_overflow pulses.
- Return (pc_src=3, no trap): pop when non-empty, decrementing ras_count. When empty, ras_underflow pulses and pc_jump is used.
- is_call is ignored for pc_src other than 2.
- Misalignment check: pc_next[$clog2(INST_BYTES)-1:0] != 0.
  - Applies to non-trap updates only.
  - On a hit: pc_out holds, no RAS push or pop, misalign pulses, fault_addr ← pc_next.
  - trap_vector is never checked.
- RAS implementation: circular buffer with a write pointer; top = entry at pointer-1. Pointers wrap modulo RAS_DEPTH.
- Reset values:
  - pc_out = RESET_VECTOR
  - epc = 0, fault_addr = 0
  - ras_count = 0, RAS pointer = 0
  - All pulse outputs = 0
  - RAS entry contents are don't-care

## Timing
- pc_out, epc, and fault_addr change on the edge where upd is sampled high, so they are valid the cycle after the fetch state. Latency is 1 cycle.
- pc_next is combinational from the current inputs, pc_out, and RAS top. It is valid in any state, including during stall.
- Pulse outputs are registered: high for exactly the one cycle after the triggering edge, low on the next edge unless retriggered.
- stall high in FETCH_STATE: nothing changes, and pulse outputs clear.
- reset is asynchronous: it clears immediately, mid-operation included, and overrides upd. The first update after deassertion uses pc_out = RESET_VECTOR.

## Test plan
- Reset mid-sequence with pc_out = 0x40: pc_out reads 0x0 without waiting for a clk edge. Then three fetch cycles with pc_src=0 give 0x4, 0x8, 0xC.
- FETCH_STATE with stall=1, then state=3'b010 with stall=0: pc_out holds at 0xC. In FETCH_STATE with pc_src=1 and pc_branch=0x100: pc_out=0x100 one cycle later.
- Call from 0x100 to pc_jump=0x200, then return: pc_out goes 0x200 then 0x104, and ras_count goes 1 then 0. A further return with pc_jump=0x300 gives pc_out=0x300 and a single-cycle ras_underflow pulse.
- Five nested calls with RAS_DEPTH=4: ras_overflow pulses on the 5th call and ras_count=4. Four returns yield push addresses 5, 4, 3, 2 in that order.
- trap=1 with pc_src=2, is_call=1, pc_out=0x208, trap_vector=0x800: pc_out=0x800, epc=0x208, ras_count unchanged.
- pc_src=1 with pc_branch=0x102: pc_out holds, misalign pulses for one cycle, fault_addr=0x102. Separately, pc_out=2^64-4 with pc_src=0 wraps pc_out to 0x0.
